mem_bank: RTL and testbench

//  Parametrised single-port data/instruction memory bank for the RISC-V core.

---
 rtl/mem_bank.sv | 170 +++++++++++++++++
 tb/tb_mem_bank.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
//   Single-port data/instruction memory bank. It accepts one read or write per
//   cycle over a valid/ready channel, writes under per-byte enables, and returns
//   a registered response one cycle after acceptance. The array itself has no
//   reset. A sequential zero-fill sweep clears it after reset (optional) or on
//   request.
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   clear_i      request zero-fill sweep (level, sampled each cycle)
//   req_valid_i  request valid
//   req_ready_o  bank accepts a request this cycle (RUN state)
//   req_we_i     1 = write, 0 = read
//   req_addr_i   word address
//   req_be_i     byte enables (writes only)
//   req_wdata_i  write data
//   rsp_valid_o  one-cycle response pulse per accepted request
//   rsp_rdata_o  read data; holds the last read value between reads
//   rsp_err_o    response error: address >= DEPTH
//   busy_o       zero-fill sweep in progress
// -----------------------------------------------------------------------------
module mem_bank #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 1024,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clear_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    init_cnt_q, init_cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Single write port shared by the sweep and by request writes; the two never
  // coincide because requests are only accepted in RUN.
  logic                mem_we;
  logic [CNT_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic [CNT_W-1:0]    addr_idx;

  assign accept   = req_valid_i & ready_q;
  assign in_range = ({1'b0, req_addr_i} < DEPTH_EXT);
  assign addr_idx = req_addr_i[CNT_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = init_cnt_q;
    mem_wdata   = '0;
    mem_be      = '1;

    unique case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (clear_i) begin
          // A new clear request during the sweep starts it over.
          init_cnt_d = '0;
        end else if (init_cnt_q == LAST_IDX) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    // A request accepted in the same cycle as clear_i still completes.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~in_range;
      if (req_we_i) begin
        if (in_range) begin
          mem_we    = 1'b1;
          mem_idx   = addr_idx;
          mem_wdata = req_wdata_i;
          mem_be    = req_be_i;
        end
      end else begin
        rsp_rdata_d = in_range ? mem[addr_idx] : '0;
      end
    end

    // Registered status outputs follow the next state.
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_INIT);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      busy_q      <= (INIT_ON_RESET != 0);
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the array has no reset so it can map onto RAM; the sweep clears it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_bank.sv
// -----------------------------------------------------------------------------
// tb_mem_bank
//   Self-checking bench for mem_bank with DEPTH=16 and ADDR_W=10, so addresses
//   16..1023 are out of range. Expected values come from a word-array model
//   that applies byte writes and tracks the last read value.
// -----------------------------------------------------------------------------
module tb_mem_bank;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int DEP = 16;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] model_mem [DEP];
  logic [DW-1:0] model_last;

  mem_bank #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .INIT_ON_RESET(1)
  ) dut (
    .clk_i(clk), .rstn_i(rst_n), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: returns the expected rdata/err for one accepted request.
  function automatic void model_access(input logic we, input logic [AW-1:0] addr,
                                       input logic [3:0] be, input logic [DW-1:0] wd,
                                       output logic [DW-1:0] exp_d, output logic exp_e);
    int a;
    a = int'(addr);
    exp_e = (a >= DEP);
    if (we) begin
      if (a < DEP)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
    end else begin
      model_last = (a < DEP) ? model_mem[a] : '0;
    end
    exp_d = model_last;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEP; i++) model_mem[i] = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; outputs then show its response.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [DW-1:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Counts cycles until busy drops, bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n_total++;
      if (req_ready !== 1'b0) $display("FAIL ready_during_sweep got=%b exp=0", req_ready);
      else n_pass++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [DW-1:0] ed;
    logic ee;
    rst_n = 1'b0;
    #12;
    n_total++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b0001)
      $display("FAIL reset_flags got=%b exp=0001", {req_ready, rsp_valid, rsp_err, busy});
    else n_pass++;
    n_total++;
    if (rsp_rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rsp_rdata);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    model_last = '0;
    wait_sweep(n);
    n_total++;
    if (n !== DEP) $display("FAIL reset_sweep_len got=%0d exp=%0d", n, DEP);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    else n_pass++;
    for (int a = 0; a < DEP; a++) begin
      do_req(1'b0, AW'(a), 4'h0, '0);
      model_access(1'b0, AW'(a), 4'h0, '0, ed, ee);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_err !== ee)
        $display("FAIL reset_read_zero a=%0d got=%b/%h/%b exp=1/%h/%b",
                 a, rsp_valid, rsp_rdata, rsp_err, ed, ee);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] ed;
    logic ee;
    do_req(1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    model_access(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0)
      $display("FAIL wr_ack got=%b/%b exp=1/0", rsp_valid, rsp_err);
    else n_pass++;
    do_req(1'b0, 10'd5, 4'h0, '0);
    model_access(1'b0, 10'd5, 4'h0, '0, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0)
      $display("FAIL rd_full got=%b/%h/%b exp=1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err);
    else n_pass++;
    // Write ack leaves rdata holding the last read value.
    do_req(1'b1, 10'd5, 4'b0101, 32'h11223344);
    model_access(1'b1, 10'd5, 4'b0101, 32'h11223344, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("FAIL wr_hold_rdata got=%b/%h exp=1/deadbeef", rsp_valid, rsp_rdata);
    else n_pass++;
    do_req(1'b0, 10'd5, 4'hF, '0);
    model_access(1'b0, 10'd5, 4'hF, '0, ed, ee);
    n_total++;
    if (rsp_rdata !== 32'hDE22BE44) $display("FAIL rd_partial got=%h exp=de22be44", rsp_rdata);
    else n_pass++;
    tick();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL valid_one_cycle got=%b exp=0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] ed;
    logic ee;
    do_req(1'b1, 10'd20, 4'hF, 32'hCAFEF00D);
    model_access(1'b1, 10'd20, 4'hF, 32'hCAFEF00D, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1)
      $display("FAIL oor_wr got=%b/%b exp=1/1", rsp_valid, rsp_err);
    else n_pass++;
    do_req(1'b0, 10'd20, 4'h0, '0);
    model_access(1'b0, 10'd20, 4'h0, '0, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0)
      $display("FAIL oor_rd got=%b/%h/%b exp=1/0/1", rsp_valid, rsp_rdata, rsp_err);
    else n_pass++;
    // Address 4 shares its low bits with 20; it must be untouched.
    for (int a = 0; a < DEP; a++) begin
      do_req(1'b0, AW'(a), 4'h0, '0);
      model_access(1'b0, AW'(a), 4'h0, '0, ed, ee);
      n_total++;
      if (rsp_rdata !== ed || rsp_err !== 1'b0)
        $display("FAIL oor_unchanged a=%0d got=%h/%b exp=%h/0", a, rsp_rdata, rsp_err, ed);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ed;
    logic ee;
    logic          we_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] ad_t [4] = '{10'd1, 10'd2, 10'd1, 10'd2};
    logic [DW-1:0] wd_t [4] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_req(we_t[i], ad_t[i], 4'hF, wd_t[i]);
      model_access(we_t[i], ad_t[i], 4'hF, wd_t[i], ed, ee);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_err !== ee)
        $display("FAIL b2b_%0d got=%b/%h/%b exp=1/%h/%b", i, rsp_valid, rsp_rdata, rsp_err, ed, ee);
      else n_pass++;
    end
    tick();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic ee;
    logic          we;
    logic [AW-1:0] ad;
    logic [3:0]    be;
    logic [DW-1:0] wd;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        tick();
        n_total++;
        if (rsp_valid !== 1'b0) $display("FAIL rnd_idle i=%0d got=%b exp=0", i, rsp_valid);
        else n_pass++;
      end else begin
        we = 1'($urandom_range(0, 1));
        ad = AW'($urandom_range(0, 23));
        be = 4'($urandom);
        wd = $urandom;
        do_req(we, ad, be, wd);
        model_access(we, ad, be, wd, ed, ee);
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_err !== ee)
          $display("FAIL rnd i=%0d we=%b a=%0d got=%b/%h/%b exp=1/%h/%b",
                   i, we, ad, rsp_valid, rsp_rdata, rsp_err, ed, ee);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clear();
    int n;
    logic [DW-1:0] ed;
    logic ee;
    do_req(1'b1, 10'd7, 4'hF, 32'h7777_7777);
    model_access(1'b1, 10'd7, 4'hF, 32'h7777_7777, ed, ee);
    do_req(1'b0, 10'd7, 4'h0, '0);
    model_access(1'b0, 10'd7, 4'h0, '0, ed, ee);
    // Clear and a write in the same cycle: the write still responds.
    clear = 1'b1;
    do_req(1'b1, 10'd3, 4'hF, 32'h3333_3333);
    model_access(1'b1, 10'd3, 4'hF, 32'h3333_3333, ed, ee);
    clear = 1'b0;
    n_total++;
    if ({rsp_valid, rsp_err, busy, req_ready} !== 4'b1010)
      $display("FAIL clr_same_cycle got=%b exp=1010", {rsp_valid, rsp_err, busy, req_ready});
    else n_pass++;
    model_clear();
    wait_sweep(n);
    n_total++;
    if (n !== DEP) $display("FAIL clr_sweep_len got=%0d exp=%0d", n, DEP);
    else n_pass++;
    for (int a = 0; a < DEP; a++) begin
      do_req(1'b0, AW'(a), 4'h0, '0);
      model_access(1'b0, AW'(a), 4'h0, '0, ed, ee);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ed)
        $display("FAIL clr_read a=%0d got=%b/%h exp=1/%h", a, rsp_valid, rsp_rdata, ed);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [DW-1:0] ed;
    logic ee;
    do_req(1'b1, 10'd9, 4'hF, 32'h9999_0009);
    model_access(1'b1, 10'd9, 4'hF, 32'h9999_0009, ed, ee);
    do_req(1'b0, 10'd9, 4'h0, '0);
    model_access(1'b0, 10'd9, 4'h0, '0, ed, ee);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b0001 || rsp_rdata !== '0)
      $display("FAIL midsweep_reset got=%b/%h exp=0001/0",
               {req_ready, rsp_valid, rsp_err, busy}, rsp_rdata);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    model_clear();
    model_last = '0;
    wait_sweep(n);
    n_total++;
    if (n !== DEP) $display("FAIL midsweep_restart_len got=%0d exp=%0d", n, DEP);
    else n_pass++;
    do_req(1'b0, 10'd9, 4'h0, '0);
    model_access(1'b0, 10'd9, 4'h0, '0, ed, ee);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ed)
      $display("FAIL midsweep_read got=%b/%h exp=1/%h", rsp_valid, rsp_rdata, ed);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    model_last = '0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
